// File: rtl/slave_bus_port_if.sv
// Serial slave channel between the bus interconnect and one slave_bus_port.
// Latency: none, this file only bundles wires.
// Backpressure: master_valid stalls address/data bits; master_ready stalls read bits.
//
// Ports (signals):
//   master_valid, master_ready, write_en, read_en, rx_address, rx_data, split_en : master -> slave
//   slave_ready, slave_valid, tx_data                                         : slave -> master
interface slave_bus_port_if;
  logic master_valid;
  logic master_ready;
  logic write_en;
  logic read_en;
  logic rx_address;
  logic rx_data;
  logic split_en;
  logic slave_ready;
  logic slave_valid;
  logic tx_data;

  modport master (
    output master_valid, master_ready, write_en, read_en, rx_address, rx_data, split_en,
    input  slave_ready, slave_valid, tx_data
  );

  modport slave (
    input  master_valid, master_ready, write_en, read_en, rx_address, rx_data, split_en,
    output slave_ready, slave_valid, tx_data
  );
endinterface

// File: rtl/slave_bus_port.sv
// Slave-side serial-to-parallel bus port in front of a block RAM (one instance per slave).
// Latency: write ADDR_LEN+DATA_LEN+1 cycles idle-to-idle; read ADDR_LEN+2+DATA_LEN (+SPLIT_CYCLES).
// Backpressure: master_valid low stalls ADDR/WDATA (aborts after TIMEOUT cycles); master_ready low holds read bits.
//
// Ports:
//   clk_i, reset_ni     : clock, asynchronous active-low reset
//   bus (slave modport) : serial request/response channel
//   mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o : RAM command (strobes are one cycle)
//   mem_rdata_i         : RAM read data, valid the cycle after mem_re_o
//   trans_done_o        : one-cycle completion pulse
module slave_bus_port #(
  parameter int ADDR_LEN     = 12,
  parameter int DATA_LEN     = 8,
  parameter int SPLIT_CYCLES = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  slave_bus_port_if.slave     bus,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic                mem_we_o,
  output logic                mem_re_o,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                trans_done_o
);

  localparam int CNT_MAX = (ADDR_LEN > DATA_LEN)
                         ? ((ADDR_LEN > SPLIT_CYCLES) ? ADDR_LEN : SPLIT_CYCLES)
                         : ((DATA_LEN > SPLIT_CYCLES) ? DATA_LEN : SPLIT_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0] SPLIT_LAST = CW'(SPLIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RDREQ, S_RDWAIT, S_SPLIT, S_RDATA
  } state_t;

  state_t              state_q;
  logic                is_write_q;
  logic                split_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [TW-1:0]       to_cnt_q;
  logic [ADDR_LEN-1:0] addr_sh_q;
  logic [DATA_LEN-1:0] data_sh_q;
  logic [DATA_LEN-1:0] tx_sh_q;
  logic                slave_ready_q;
  logic                slave_valid_q;
  logic                tx_data_q;
  logic [ADDR_LEN-1:0] mem_addr_q;
  logic [DATA_LEN-1:0] mem_wdata_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic                trans_done_q;

  // Bits arrive LSB first: shift right so the first bit ends up at index 0.
  logic [ADDR_LEN-1:0] addr_sh_d;
  logic [DATA_LEN-1:0] data_sh_d;
  assign addr_sh_d = {bus.rx_address, addr_sh_q[ADDR_LEN-1:1]};
  assign data_sh_d = {bus.rx_data, data_sh_q[DATA_LEN-1:1]};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      is_write_q    <= 1'b0;
      split_q       <= 1'b0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      tx_sh_q       <= '0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
      tx_data_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      trans_done_q  <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      trans_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.master_valid && (bus.write_en ^ bus.read_en)) begin
            addr_sh_q     <= addr_sh_d;
            bit_cnt_q     <= CW'(1);
            to_cnt_q      <= '0;
            is_write_q    <= bus.write_en;
            split_q       <= bus.split_en;
            slave_ready_q <= 1'b0;
            state_q       <= S_ADDR;
          end
        end

        S_ADDR, S_WDATA: begin
          if (bus.master_valid) begin
            to_cnt_q <= '0;
            if (state_q == S_ADDR) begin
              addr_sh_q <= addr_sh_d;
              if (bit_cnt_q == ADDR_LAST) begin
                bit_cnt_q <= '0;
                if (is_write_q) begin
                  state_q <= S_WDATA;
                end else begin
                  state_q    <= S_RDREQ;
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= addr_sh_d;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
              end
            end else begin
              data_sh_q <= data_sh_d;
              if (bit_cnt_q == DATA_LAST) begin
                bit_cnt_q    <= '0;
                state_q      <= S_WRITE;
                mem_we_q     <= 1'b1;
                mem_addr_q   <= addr_sh_q;
                mem_wdata_q  <= data_sh_d;
                trans_done_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
              end
            end
          end else if (to_cnt_q == TO_LAST) begin
            // Master went silent: drop the transaction without touching the RAM.
            state_q       <= S_IDLE;
            slave_ready_q <= 1'b1;
            bit_cnt_q     <= '0;
            to_cnt_q      <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end

        S_WRITE: begin
          state_q       <= S_IDLE;
          slave_ready_q <= 1'b1;
          bit_cnt_q     <= '0;
        end

        S_RDREQ: begin
          state_q <= S_RDWAIT;
        end

        S_RDWAIT: begin
          tx_sh_q <= mem_rdata_i;
          if (split_q) begin
            bit_cnt_q <= '0;
            state_q   <= S_SPLIT;
          end else begin
            slave_valid_q <= 1'b1;
            tx_data_q     <= mem_rdata_i[0];
            state_q       <= S_RDATA;
          end
        end

        S_SPLIT: begin
          if (bit_cnt_q == SPLIT_LAST) begin
            bit_cnt_q     <= '0;
            slave_valid_q <= 1'b1;
            tx_data_q     <= tx_sh_q[0];
            state_q       <= S_RDATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end

        S_RDATA: begin
          if (bus.master_ready) begin
            if (bit_cnt_q == DATA_LAST) begin
              // Completion is registered to keep master_ready off the output
              // path, so the pulse lands in the first IDLE cycle.
              slave_valid_q <= 1'b0;
              tx_data_q     <= 1'b0;
              trans_done_q  <= 1'b1;
              slave_ready_q <= 1'b1;
              bit_cnt_q     <= '0;
              state_q       <= S_IDLE;
            end else begin
              tx_sh_q   <= {1'b0, tx_sh_q[DATA_LEN-1:1]};
              tx_data_q <= tx_sh_q[1];
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_q       <= S_IDLE;
          slave_ready_q <= 1'b1;
          bit_cnt_q     <= '0;
        end
      endcase
    end
  end

  assign bus.slave_ready = slave_ready_q;
  assign bus.slave_valid = slave_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_we_o        = mem_we_q;
  assign mem_re_o        = mem_re_q;
  assign trans_done_o    = trans_done_q;

endmodule
